// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bus between the fetch/data arbiter and the single-ported unified memory.
//   master : arbiter side. Drives MemReq/MemWe/MemAdr/MemWData/MemBe and
//            receives MemRData/MemReady.
//   slave  : memory side.
// A request is held constant from MemReq rising until the cycle MemReady is
// seen. MemRData is only meaningful in that MemReady cycle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  MemReq;
    logic                  MemWe;
    logic [ADDR_W-1:0]     MemAdr;
    logic [DATA_W-1:0]     MemWData;
    logic [DATA_W/8-1:0]   MemBe;
    logic [DATA_W-1:0]     MemRData;
    logic                  MemReady;

    modport master (
        output MemReq, MemWe, MemAdr, MemWData, MemBe,
        input  MemRData, MemReady
    );

    modport slave (
        input  MemReq, MemWe, MemAdr, MemWData, MemBe,
        output MemRData, MemReady
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (F) and data
// access (M) of the pipelined RV32I core. One access is outstanding at a time.
// When both stages are waiting, the data access goes first because it belongs
// to the older instruction. A fetched word is buffered until the F stage takes
// it.
// Ports:
//   clk, reset_n                 clock; synchronous active-low reset
//   PCF, InstrReqF, InstrTakeF   fetch address, fetch request (level), consume
//   FlushF                       discard the buffered or in-flight fetch
//   InstrF, InstrValidF          buffered instruction and its valid flag
//   StallMemF                    InstrReqF & !InstrValidF
//   DataReqM/DataWeM/DataAdrM/   load/store request, held until DataDoneM
//   WriteDataM/ByteEnM
//   ReadDataM, DataDoneM         registered load data; one-cycle completion
//   StallMemM                    DataReqM & !DataDoneM
//   memBus (master)              registered memory request, MemRData/MemReady
//   BusErr                       sticky timeout error
// Build option: define MEM_TIMEOUT_EN to abandon an access after TIMEOUT busy
// cycles without MemReady. Without it the arbiter waits indefinitely and
// BusErr is tied low.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   PCF,
    input  logic                InstrReqF,
    input  logic                InstrTakeF,
    input  logic                FlushF,
    output logic [DATA_W-1:0]   InstrF,
    output logic                InstrValidF,
    output logic                StallMemF,
    input  logic                DataReqM,
    input  logic                DataWeM,
    input  logic [ADDR_W-1:0]   DataAdrM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [DATA_W/8-1:0] ByteEnM,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic                DataDoneM,
    output logic                StallMemM,
    mem_port_arbiter_if.master  memBus,
    output logic                BusErr
);
    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : gTimeoutRange
        $error("mem_port_arbiter: TIMEOUT must be 2..1023");
    end

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    state_t state;
    logic   dropFlag;   // in-flight fetch was flushed; discard its result

`ifdef MEM_TIMEOUT_EN
    localparam logic [9:0] TimerLast = 10'(TIMEOUT - 1);
    logic [9:0] timer;  // busy cycles elapsed without MemReady
`else
    assign BusErr = 1'b0;
`endif

    assign StallMemF = InstrReqF & ~InstrValidF;
    assign StallMemM = DataReqM & ~DataDoneM;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            dropFlag        <= 1'b0;
            InstrF          <= '0;
            InstrValidF     <= 1'b0;
            ReadDataM       <= '0;
            DataDoneM       <= 1'b0;
            memBus.MemReq   <= 1'b0;
            memBus.MemWe    <= 1'b0;
            memBus.MemAdr   <= '0;
            memBus.MemWData <= '0;
            memBus.MemBe    <= '0;
`ifdef MEM_TIMEOUT_EN
            timer           <= '0;
            BusErr          <= 1'b0;
`endif
        end else begin
            DataDoneM <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            // Zero while idle, so every access starts counting from 0.
            timer <= (state == IDLE) ? '0 : timer + 10'd1;
`endif
            // A completing fetch below can re-set valid; it only runs while
            // the buffer is empty, so the two never collide.
            if ((InstrTakeF && InstrValidF) || FlushF)
                InstrValidF <= 1'b0;

            case (state)
                IDLE: begin
                    // DataDoneM high means M is advancing this cycle; a
                    // still-asserted DataReqM is the finished access.
                    if (DataReqM && !DataDoneM) begin
                        state           <= BUSY_D;
                        memBus.MemReq   <= 1'b1;
                        memBus.MemWe    <= DataWeM;
                        memBus.MemAdr   <= DataAdrM;
                        memBus.MemWData <= WriteDataM;
                        memBus.MemBe    <= ByteEnM;
                    end else if (InstrReqF && !InstrValidF && !FlushF) begin
                        state           <= BUSY_I;
                        memBus.MemReq   <= 1'b1;
                        memBus.MemWe    <= 1'b0;
                        memBus.MemAdr   <= PCF;
                        memBus.MemWData <= '0;
                        memBus.MemBe    <= '0;
                    end
                end
                BUSY_D: begin
                    if (memBus.MemReady) begin
                        state         <= IDLE;
                        memBus.MemReq <= 1'b0;
                        DataDoneM     <= 1'b1;
                        if (!memBus.MemWe)
                            ReadDataM <= memBus.MemRData;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timer == TimerLast) begin
                        state         <= IDLE;
                        memBus.MemReq <= 1'b0;
                        DataDoneM     <= 1'b1;
                        ReadDataM     <= '0;
                        BusErr        <= 1'b1;
                    end
`endif
                end
                BUSY_I: begin
                    if (memBus.MemReady) begin
                        state         <= IDLE;
                        memBus.MemReq <= 1'b0;
                        dropFlag      <= 1'b0;
                        // A flush arriving with MemReady also kills the word.
                        if (!dropFlag && !FlushF) begin
                            InstrF      <= memBus.MemRData;
                            InstrValidF <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timer == TimerLast) begin
                        state         <= IDLE;
                        memBus.MemReq <= 1'b0;
                        dropFlag      <= 1'b0;
                        BusErr        <= 1'b1;
                    end
`endif
                    else if (FlushF) begin
                        dropFlag <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
